// File: rtl/div_issue_ctrl.sv
// Issue sequencer for the shared multi-cycle divider: holds operands across a run,
// drains the divider on flush (it cannot abort) and buffers the selected result.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic [4:0]  req_tag,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_tag,
    output logic        busy,
    output logic        div_en,
    output logic        div_signed,
    output logic [31:0] div_num,
    output logic [31:0] div_den,
    input  logic [63:0] div_result,
    input  logic        div_complete,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Handshakes: a request transfers on a cycle where req_valid & req_ready are both
    // high; a response transfers on a cycle where rsp_valid & rsp_ready are both high.

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_is_mod;
    logic        r_signed;
    logic [31:0] r_num;
    logic [31:0] r_den;
    logic [4:0]  r_tag;
    logic [31:0] r_rsp_data;
    logic [4:0]  r_rsp_tag;
    logic        w_accept;
    logic        w_capture;

    assign w_accept  = req_valid & req_ready;
    assign w_capture = (r_state == ST_RUN) & div_complete & ~flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_RUN;
            ST_RUN: begin
                if (div_complete)
                    w_next = flush ? ST_IDLE : ST_HOLD;
                else if (flush)
                    w_next = ST_DRAIN;
            end
            ST_DRAIN: if (div_complete) w_next = ST_IDLE;
            ST_HOLD:  if (rsp_ready | flush) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Operands only load in IDLE, so they cannot move while the divider is enabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_mod <= 1'b0;
            r_signed <= 1'b0;
            r_num    <= 32'd0;
            r_den    <= 32'd0;
            r_tag    <= 5'd0;
        end else if (w_accept) begin
            r_is_mod <= req_op[1];
            r_signed <= ~req_op[0];
            r_num    <= req_src1;
            r_den    <= req_src2;
            r_tag    <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_data <= 32'd0;
            r_rsp_tag  <= 5'd0;
        end else if (w_capture) begin
            r_rsp_data <= r_is_mod ? div_result[31:0] : div_result[63:32];
            r_rsp_tag  <= r_tag;
        end
    end

    assign req_ready  = (r_state == ST_IDLE) & ~flush;
    assign div_en     = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign rsp_valid  = (r_state == ST_HOLD);
    assign busy       = (r_state != ST_IDLE);
    assign div_signed = r_signed;
    assign div_num    = r_num;
    assign div_den    = r_den;
    assign rsp_data   = r_rsp_data;
    assign rsp_tag    = r_rsp_tag;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a stand-in divider, a cycle-timeline reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_div_issue_ctrl;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [4:0]  req_tag;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        busy;
    logic        div_en;
    logic        div_signed;
    logic [31:0] div_num;
    logic [31:0] div_den;
    logic [63:0] div_result;
    logic        div_complete;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    div_issue_ctrl dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .busy(busy),
        .div_en(div_en), .div_signed(div_signed), .div_num(div_num), .div_den(div_den),
        .div_result(div_result), .div_complete(div_complete),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- divider stand-in: completes on its 34th enabled cycle ----------------
    logic [5:0] div_cnt;
    always @(posedge clk) begin
        if (!resetn)
            div_cnt <= 6'd0;
        else if (div_en)
            div_cnt <= (div_cnt == 6'd33) ? 6'd0 : div_cnt + 6'd1;
    end
    assign div_complete = div_en && (div_cnt == 6'd33);

    always_comb begin
        div_result = {32'hFFFF_FFFF, div_num};
        if (div_den != 32'd0) begin
            if (div_signed)
                div_result = {$signed(div_num) / $signed(div_den), $signed(div_num) % $signed(div_den)};
            else
                div_result = {div_num / div_den, div_num % div_den};
        end
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            2'b00:   ref_result = sa / sb;
            2'b01:   ref_result = a / b;
            2'b10:   ref_result = sa % sb;
            default: ref_result = a % b;
        endcase
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    // The model tracks time left in the divider run, whether the run was cancelled,
    // and whether a response is waiting; outputs follow from those facts.
    int          m_left;
    bit          m_flushed;
    bit          m_hold;
    logic [31:0] m_a, m_b, m_data;
    logic        m_sgn;
    logic [4:0]  m_tag;

    initial begin
        m_left = 0; m_flushed = 0; m_hold = 0;
        m_a = '0; m_b = '0; m_data = '0; m_sgn = 0; m_tag = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_div_en", {31'd0, div_en}, 32'd0);
                chk("rst_req_ready", {31'd0, req_ready}, {31'd0, ~flush});
                chk("rst_rsp_data", rsp_data, 32'd0);
                chk("rst_div_num", div_num, 32'd0);
                m_left = 0; m_flushed = 0; m_hold = 0;
            end else begin
                logic e_en, e_busy, e_rr;
                e_en   = (m_left > 0);
                e_busy = e_en || m_hold;
                e_rr   = !e_busy && !flush;
                chk("div_en", {31'd0, div_en}, {31'd0, e_en});
                chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_hold});
                chk("busy", {31'd0, busy}, {31'd0, e_busy});
                chk("req_ready", {31'd0, req_ready}, {31'd0, e_rr});
                if (e_en) begin
                    chk("div_num", div_num, m_a);
                    chk("div_den", div_den, m_b);
                    chk("div_signed", {31'd0, div_signed}, {31'd0, m_sgn});
                end
                if (m_hold) begin
                    chk("rsp_data", rsp_data, m_data);
                    chk("rsp_tag", {27'd0, rsp_tag}, {27'd0, m_tag});
                end
                // advance to the next cycle using this cycle's inputs
                if (m_hold) begin
                    if (rsp_ready || flush) m_hold = 0;
                end else if (m_left > 0) begin
                    if (m_left == 1) begin
                        if (!m_flushed && !flush) m_hold = 1;
                        m_flushed = 0;
                    end else if (flush) begin
                        m_flushed = 1;
                    end
                    m_left--;
                end else if (req_valid && e_rr) begin
                    m_left = 34;
                    m_a    = req_src1;
                    m_b    = req_src2;
                    m_sgn  = ~req_op[0];
                    m_data = ref_result(req_op, req_src1, req_src2);
                    m_tag  = req_tag;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        bit ok;
        ok = 0;
        req_op = op; req_src1 = a; req_src2 = b; req_tag = tag; req_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n, output int en_cnt);
        n = 0;
        en_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (div_en) en_cnt++;
            if (rsp_valid) break;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
        int n, en;
        send(op, a, b, tag);
        wait_rsp(n, en);
        chk({name, "_latency"}, n, 32'd35);
        chk({name, "_en_cycles"}, en, 32'd34);
        chk({name, "_data"}, rsp_data, exp);
        chk({name, "_tag"}, {27'd0, rsp_tag}, {27'd0, tag});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n, en;
        bit saw;
        logic [31:0] held_data;
        resetn = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
        req_tag = '0; flush = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_tag", {27'd0, rsp_tag}, 32'd0);
        chk("reset_div_signed", {31'd0, div_signed}, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // the four ops on -7 / 2
        run_op("div_w", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
        run_op("mod_w", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run_op("div_wu", 2'b01, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC);
        run_op("mod_wu", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd31, 32'h0000_0001);

        // flush pulsed in RUN cycle T+10
        send(2'b00, 32'd1234, 32'd11, 5'd2);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        en = 0;
        saw = 0;
        for (int k = 11; k <= 35; k++) begin
            @(negedge clk);
            if (k <= 34 && div_en) en++;
            if (rsp_valid) saw = 1;
            if (k == 35) begin
                chk("flush_ready_T35", {31'd0, req_ready}, 32'd1);
                chk("flush_en_low_T35", {31'd0, div_en}, 32'd0);
            end
        end
        chk("flush_drain_en", en, 32'd24);
        chk("flush_no_rsp", {31'd0, saw}, 32'd0);
        @(posedge clk);
        #1;
        run_op("after_flush", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14);

        // response back-pressure for five cycles
        rsp_ready = 1'b0;
        send(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd17);
        wait_rsp(n, en);
        chk("hold_latency", n, 32'd35);
        chk("hold_data", rsp_data, 32'hFFFF_FEB3);
        held_data = rsp_data;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("hold_stable_data", rsp_data, held_data);
            chk("hold_stable_tag", {27'd0, rsp_tag}, 32'd17);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_last_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_released_idle", {30'd0, dbg_state}, 32'd0);
        chk("hold_released_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // flush coincident with div_complete
        send(2'b10, 32'd20, 32'd6, 5'd4);
        repeat (33) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("coinc_complete", {31'd0, div_complete}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("coinc_idle", {30'd0, dbg_state}, 32'd0);
        chk("coinc_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // flush during HOLD
        rsp_ready = 1'b0;
        send(2'b11, 32'd20, 32'd6, 5'd8);
        wait_rsp(n, en);
        chk("hflush_latency", n, 32'd35);
        chk("hflush_data", rsp_data, 32'd2);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("hflush_valid_before", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("hflush_idle", {30'd0, dbg_state}, 32'd0);
        chk("hflush_dropped", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;

        // flush together with a request in IDLE blocks acceptance
        req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; req_src1 = 32'd9; req_src2 = 32'd3;
        @(negedge clk);
        chk("idle_flush_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_not_taken", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // asynchronous reset in RUN cycle T+20
        send(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        #1;
        chk("async_rst_state", {30'd0, dbg_state}, 32'd0);
        chk("async_rst_div_en", {31'd0, div_en}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_div_num", div_num, 32'd0);
        chk("async_rst_div_den", div_den, 32'd0);
        chk("async_rst_rsp_data", rsp_data, 32'd0);
        chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        run_op("post_reset", 2'b10, 32'h8000_0000, 32'd3, 5'd9, 32'hFFFF_FFFE);

        // model self-pin: the reference arithmetic against hand values
        chk("model_div_w", ref_result(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_mod_w", ref_result(2'b10, 32'h8000_0000, 32'd3), 32'hFFFF_FFFE);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
